cache_mem_arbiter: RTL and testbench

Round-robin arbiter that merges the memory-side ports of several caches (instruction cache, data cache) onto the single req/gnt/rvalid memory port. It sits directly downstream of the set-associative cache and upstream of the memory/bus. It allows one outstanding transaction at a time and steers the response to the master that owns the transaction. A watchdog turns lost responses into error responses.

---
 rtl/cache_mem_arbiter.sv | 103 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin merge of cache memory ports onto one req/gnt/rvalid port,
// with a single outstanding transaction and a watchdog that converts lost responses into errors.
module cache_mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_be_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    output logic [NUM_MASTERS*32-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_error_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic                      mem_req_o,
    input  logic [31:0]               mem_rdata_i,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic                      mem_error_i,
    output logic                      busy_o
);
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, STALE} state_t;

    state_t        state;
    logic [OW-1:0] owner, prio, winner, idx, sel, next;
    logic [WW-1:0] wd_cnt;
    logic          fwd, rsp, tmo;

    // Scan downwards so the lowest offset from prio is the last (winning) assignment.
    always_comb begin
        winner = prio;
        idx    = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = OW'((int'(prio) + i) % NUM_MASTERS);
            if (m_req_i[idx]) winner = idx;
        end
    end

    always_comb begin
        next = owner == OW'(NUM_MASTERS - 1) ? '0 : owner + 1'b1;
        sel  = state == IDLE ? winner : owner;
        fwd  = !reset && (state == REQ || (state == IDLE && |m_req_i));
        rsp  = !reset && state == WAIT && mem_rvalid_i;
        tmo  = !reset && TIMEOUT_CYCLES != 0 && state == WAIT && !mem_rvalid_i && wd_cnt == WD_LAST;
        mem_req_o   = fwd;
        mem_addr_o  = fwd ? m_addr_i[32*sel +: 32] : '0;
        mem_wdata_o = fwd ? m_wdata_i[32*sel +: 32] : '0;
        mem_we_o    = fwd ? m_we_i[sel] : 1'b0;
        mem_be_o    = fwd ? m_be_i[4*sel +: 4] : '0;
        busy_o      = !reset && state != IDLE;
        m_gnt_o     = '0;
        m_rvalid_o  = '0;
        m_error_o   = '0;
        m_rdata_o   = '0;
        if (fwd && mem_gnt_i) m_gnt_o[sel] = 1'b1;
        if (rsp || tmo) begin
            m_rvalid_o[owner]          = 1'b1;
            m_error_o[owner]           = rsp ? mem_error_i : 1'b1;
            m_rdata_o[32*owner +: 32]  = rsp ? mem_rdata_i : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            prio   <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (|m_req_i) begin
                    owner  <= winner;
                    wd_cnt <= '0;
                    state  <= mem_gnt_i ? WAIT : REQ;
                end
                REQ: if (mem_gnt_i) begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (mem_rvalid_i || tmo) begin
                        prio  <= next;
                        state <= mem_rvalid_i ? IDLE : STALE;
                    end
                end
                STALE: if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed stimulus pushes expected grants/responses into queues;
// a negedge monitor pops and compares whenever the arbiter presents a grant or response.
module tb_cache_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_req_i = '0, m_we_i = '0, m_gnt_o, m_rvalid_o, m_error_o;
    logic [63:0] m_addr_i = '0, m_wdata_i = '0, m_rdata_o;
    logic [7:0]  m_be_i = '0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
    logic        mem_we_o, mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_error_i = 1'b0, busy_o;
    logic [3:0]  mem_be_o;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [1:0]  vec;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gnt_t;
    typedef struct {
        logic [1:0]  vec;
        logic [1:0]  err;
        logic [63:0] rdata;
    } rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];

    cache_mem_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_we_i(m_we_i), .m_be_i(m_be_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_error_o(m_error_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_req_o(mem_req_o),
        .mem_rdata_i(mem_rdata_i), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_error_i(mem_error_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [1:0] req, input logic g, input logic rv, input logic [31:0] rd, input logic er);
        @(posedge clk);
        #1;
        m_req_i = req;
        mem_gnt_i = g;
        mem_rvalid_i = rv;
        mem_rdata_i = rd;
        mem_error_i = er;
    endtask

    always @(negedge clk) begin : monitor
        gnt_t g;
        rsp_t r;
        if (!reset) begin
            if (m_gnt_o != 2'b00) begin
                if (gq.size() == 0) chk("unexpected gnt", 64'(m_gnt_o), 64'h0);
                else begin
                    g = gq.pop_front();
                    chk("gnt", 64'(m_gnt_o), 64'(g.vec));
                    chk("gnt addr", 64'(mem_addr_o), 64'(g.addr));
                    chk("gnt we", 64'(mem_we_o), 64'(g.we));
                    chk("gnt wdata", 64'(mem_wdata_o), 64'(g.wdata));
                    chk("gnt be", 64'(mem_be_o), 64'(g.be));
                end
            end
            if (m_rvalid_o != 2'b00) begin
                if (rq.size() == 0) chk("unexpected rvalid", 64'(m_rvalid_o), 64'h0);
                else begin
                    r = rq.pop_front();
                    chk("rvalid", 64'(m_rvalid_o), 64'(r.vec));
                    chk("error", 64'(m_error_o), 64'(r.err));
                    chk("rdata", m_rdata_o, r.rdata);
                end
            end else chk("quiet rdata/error", {m_rdata_o[61:0], m_error_o}, 64'h0);
        end
    end

    initial begin
        m_req_i   = 2'b01;
        m_addr_i  = {32'h0000_0180, 32'h0000_0100};
        m_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
        m_be_i    = 8'h3F;
        @(negedge clk);
        chk("reset mem_req", 64'(mem_req_o), 64'h0);
        chk("reset busy", 64'(busy_o), 64'h0);
        chk("reset gnt", 64'(m_gnt_o), 64'h0);
        chk("reset rvalid", 64'(m_rvalid_o), 64'h0);
        chk("reset mem_addr", 64'(mem_addr_o), 64'h0);
        chk("reset mem_be", 64'(mem_be_o), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_req_i = 2'b00;

        // single master, same-cycle grant, response next cycle
        cyc(2'b01, 1, 0, 0, 0);
        gq.push_back('{2'b01, 32'h100, 1'b0, 32'hAAAA_0000, 4'hF});
        cyc(2'b00, 0, 1, 32'hDEAD_BEEF, 0);
        rq.push_back('{2'b01, 2'b00, 64'h0000_0000_DEAD_BEEF});
        cyc(2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // continuous requests alternate m0,m1,m0,m1
        m_addr_i = {32'h0000_0300, 32'h0000_0200};
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 1, 0, 0, 0);
            if (k % 2 == 0) gq.push_back('{2'b01, 32'h200, 1'b0, 32'hAAAA_0000, 4'hF});
            else            gq.push_back('{2'b10, 32'h300, 1'b0, 32'hBBBB_0001, 4'h3});
            cyc(2'b11, 0, 1, 32'h1000 + k, 0);
            if (k % 2 == 0) rq.push_back('{2'b01, 2'b00, {32'h0, 32'h1000 + k}});
            else            rq.push_back('{2'b10, 2'b00, {32'h1000 + k, 32'h0}});
        end

        // m1 stalled in REQ for 3 cycles while m0 also requests; m1 response carries an error
        cyc(2'b10, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc(2'b11, 0, 0, 0, 0);
            @(negedge clk);
            chk("stall addr", 64'(mem_addr_o), 64'h300);
            chk("stall mem_req", 64'(mem_req_o), 64'h1);
        end
        cyc(2'b11, 1, 0, 0, 0);
        gq.push_back('{2'b10, 32'h300, 1'b0, 32'hBBBB_0001, 4'h3});
        cyc(2'b01, 0, 1, 32'hCAFE_0001, 1);
        rq.push_back('{2'b10, 2'b10, {32'hCAFE_0001, 32'h0}});
        cyc(2'b01, 1, 0, 0, 0);
        gq.push_back('{2'b01, 32'h200, 1'b0, 32'hAAAA_0000, 4'hF});
        cyc(2'b00, 0, 1, 32'h55, 0);
        rq.push_back('{2'b01, 2'b00, 64'h55});

        // m0 write with no response: timeout on 4th WAIT cycle, then STALE
        m_we_i = 2'b01;
        cyc(2'b01, 1, 0, 0, 0);
        gq.push_back('{2'b01, 32'h200, 1'b1, 32'hAAAA_0000, 4'hF});
        for (int k = 0; k < 3; k++) cyc(2'b00, 0, 0, 32'h7777_7777, 0);
        cyc(2'b00, 0, 0, 32'h7777_7777, 0);
        rq.push_back('{2'b01, 2'b01, 64'h0});
        m_we_i = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cyc(2'b10, 1, 0, 0, 0);
            @(negedge clk);
            chk("stale mem_req", 64'(mem_req_o), 64'h0);
            chk("stale busy", 64'(busy_o), 64'h1);
        end
        cyc(2'b10, 1, 1, 32'h99, 0);
        @(negedge clk);
        chk("stale absorb mem_req", 64'(mem_req_o), 64'h0);
        cyc(2'b10, 1, 0, 0, 0);
        gq.push_back('{2'b10, 32'h300, 1'b0, 32'hBBBB_0001, 4'h3});
        cyc(2'b00, 0, 1, 32'h1234, 0);
        rq.push_back('{2'b10, 2'b00, {32'h1234, 32'h0}});

        // reset in WAIT with rvalid pending; prio must return to 0
        cyc(2'b01, 1, 0, 0, 0);
        gq.push_back('{2'b01, 32'h200, 1'b0, 32'hAAAA_0000, 4'hF});
        cyc(2'b00, 0, 1, 32'h11, 0);
        rq.push_back('{2'b01, 2'b00, 64'h11});
        cyc(2'b01, 1, 0, 0, 0);
        gq.push_back('{2'b01, 32'h200, 1'b0, 32'hAAAA_0000, 4'hF});
        cyc(2'b10, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_req_i = 2'b11;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'hEE;
        #1;
        chk("async reset rvalid", 64'(m_rvalid_o), 64'h0);
        chk("async reset gnt", 64'(m_gnt_o), 64'h0);
        chk("async reset mem_req", 64'(mem_req_o), 64'h0);
        chk("async reset busy", 64'(busy_o), 64'h0);
        chk("async reset rdata", m_rdata_o, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_req_i = 2'b11;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b0;
        gq.push_back('{2'b01, 32'h200, 1'b0, 32'hAAAA_0000, 4'hF});
        cyc(2'b10, 0, 1, 32'h22, 0);
        rq.push_back('{2'b01, 2'b00, 64'h22});
        cyc(2'b10, 1, 0, 0, 0);
        gq.push_back('{2'b10, 32'h300, 1'b0, 32'hBBBB_0001, 4'h3});
        cyc(2'b00, 0, 1, 32'h33, 0);
        rq.push_back('{2'b10, 2'b00, {32'h33, 32'h0}});
        cyc(2'b00, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("grant queue drained", 64'(gq.size()), 64'h0);
        chk("response queue drained", 64'(rq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
